// File: rtl/sprite_row_fetch.sv
// sprite_row_fetch: per-scanline sprite row prefetch sequencer.
// During hblank it walks the sprites, finds those covering the upcoming
// line and copies each hit sprite's row from the shared sprite memory into
// the line buffer. Each word is fetched through a req/grant port and written
// back one cycle after the request is accepted.
module sprite_row_fetch #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_W    = 10,
    parameter int          SPRITE_H    = 10,
    parameter int          DATA_W      = 4,
    parameter logic [15:0] SPRITE_BASE = 16'd0
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           line_start,
    input  logic [9:0]                     NextY,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [8*NUM_SPRITES-1:0]       sprite_y,
    output logic                           mem_req,
    output logic [15:0]                    mem_address,
    input  logic                           mem_grant,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           buf_we,
    output logic [$clog2(NUM_SPRITES)-1:0] buf_sel,
    output logic [3:0]                     buf_idx,
    output logic [DATA_W-1:0]              buf_data,
    output logic [NUM_SPRITES-1:0]         row_hit,
    output logic                           busy,
    output logic                           done
);

    localparam int          SW        = $clog2(NUM_SPRITES);
    localparam logic [SW-1:0] LAST_S  = SW'(NUM_SPRITES - 1);
    localparam logic [3:0]  LAST_C    = 4'(SPRITE_W - 1);
    localparam logic [15:0] SPR_WORDS = 16'(SPRITE_W * SPRITE_H);
    localparam logic [15:0] ROW_WORDS = 16'(SPRITE_W);
    localparam logic [9:0]  HEIGHT    = 10'(SPRITE_H);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SW-1:0]          s_q;
    logic [3:0]             c_q;
    logic [9:0]             ylat_q;
    logic [3:0]             row_q;
    logic [NUM_SPRITES-1:0] row_hit_q;
    logic                   pv_q;
    logic [SW-1:0]          ps_q;
    logic [3:0]             pc_q;

    logic [9:0]  top_y;
    logic [9:0]  diff;
    logic        hit;
    logic        accept;
    logic [15:0] fetch_addr;

    // Coverage test for the sprite currently under inspection; sprite
    // enable and position are taken live, so late register updates count.
    assign top_y = {2'b00, sprite_y[{s_q, 3'b000} +: 8]};
    assign diff  = ylat_q - top_y;
    assign hit   = sprite_en[s_q] && (ylat_q >= top_y) && (diff < HEIGHT);

    // Word address of pixel (row, c) of sprite s; wraps naturally at 16 bits.
    assign fetch_addr = SPRITE_BASE + 16'(s_q) * SPR_WORDS
                      + 16'(row_q) * ROW_WORDS + 16'(c_q);

    assign mem_req     = (state_q == FETCH);
    assign mem_address = mem_req ? fetch_addr : 16'd0;
    assign accept      = mem_req && mem_grant;

    // Read data arrives one cycle after accept and goes straight to the buffer.
    assign buf_we   = pv_q;
    assign buf_sel  = ps_q;
    assign buf_idx  = pc_q;
    assign buf_data = mem_rdata;

    assign row_hit = row_hit_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    // Sequencer: sprite scan, row fetch, writeback tracking and abort/restart.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            ylat_q    <= '0;
            row_q     <= '0;
            row_hit_q <= '0;
            pv_q      <= 1'b0;
            ps_q      <= '0;
            pc_q      <= '0;
        end else begin
            // An accepted word is written back next cycle even if the line
            // is restarted in the meantime.
            pv_q <= accept;
            if (accept) begin
                ps_q <= s_q;
                pc_q <= c_q;
            end

            if (line_start) begin
                ylat_q    <= NextY;
                s_q       <= '0;
                row_hit_q <= '0;
                state_q   <= CHECK;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    CHECK: begin
                        if (hit) begin
                            row_hit_q[s_q] <= 1'b1;
                            row_q          <= diff[3:0];
                            c_q            <= '0;
                            state_q        <= FETCH;
                        end else if (s_q == LAST_S) begin
                            state_q <= DONE;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                    FETCH: begin
                        if (accept) begin
                            if (c_q != LAST_C) begin
                                c_q <= c_q + 4'd1;
                            end else if (s_q == LAST_S) begin
                                state_q <= DRAIN;
                            end else begin
                                s_q     <= s_q + SW'(1);
                                state_q <= CHECK;
                            end
                        end
                    end
                    DRAIN: begin
                        state_q <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Testbench for sprite_row_fetch: a reference model of the fetch rules
// fills an expected-address queue at each line_start; a monitor checks
// requests and line-buffer writes against it while a memory responder
// drives grant patterns and address-derived read data.
module tb_sprite_row_fetch;

    localparam int NS = 4;
    localparam int SW = 10;
    localparam int SH = 10;
    localparam int DW = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  sel;
        logic [3:0]  idx;
    } req_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } wr_t;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic            line_start = 1'b0;
    logic [9:0]      NextY = '0;
    logic [NS-1:0]   sprite_en = '0;
    logic [8*NS-1:0] sprite_y = '0;
    logic            mem_req;
    logic [15:0]     mem_address;
    logic            mem_grant = 1'b1;
    logic [DW-1:0]   mem_rdata = '0;
    logic            buf_we;
    logic [1:0]      buf_sel;
    logic [3:0]      buf_idx;
    logic [DW-1:0]   buf_data;
    logic [NS-1:0]   row_hit;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int grant_mode = 0;
    int stalls = 0;
    int done_cnt = 0;

    req_t exp_addr_q[$];
    wr_t  exp_wr_q[$];
    logic [NS-1:0] exp_hit = '0;
    int   exp_h = 0;
    bit   exp_last = 1'b0;

    sprite_row_fetch dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .line_start (line_start),
        .NextY      (NextY),
        .sprite_en  (sprite_en),
        .sprite_y   (sprite_y),
        .mem_req    (mem_req),
        .mem_address(mem_address),
        .mem_grant  (mem_grant),
        .mem_rdata  (mem_rdata),
        .buf_we     (buf_we),
        .buf_sel    (buf_sel),
        .buf_idx    (buf_idx),
        .buf_data   (buf_data),
        .row_hit    (row_hit),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] mem_fn(input logic [15:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ 4'h5;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: which sprites cover line y, and the word addresses
    // of their rows in scan order.
    task automatic load_model(input logic [9:0] y);
        int yi;
        yi = int'(y);
        exp_addr_q.delete();
        exp_hit  = '0;
        exp_h    = 0;
        exp_last = 1'b0;
        for (int s = 0; s < NS; s++) begin
            int top;
            top = int'(sprite_y[8*s +: 8]);
            if (sprite_en[s] && yi >= top && yi < top + SH) begin
                exp_hit[s] = 1'b1;
                exp_h++;
                if (s == NS - 1) exp_last = 1'b1;
                for (int c = 0; c < SW; c++) begin
                    req_t r;
                    r.addr = 16'(s * SW * SH + (yi - top) * SW + c);
                    r.sel  = 2'(s);
                    r.idx  = 4'(c);
                    exp_addr_q.push_back(r);
                end
            end
        end
    endtask

    // Monitor: checks every request and writeback against the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (mem_req) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %0h expected no request", mem_address);
                end else begin
                    chk("mem_address", 32'(mem_address), 32'(exp_addr_q[0].addr));
                    if (mem_grant) begin
                        req_t r;
                        wr_t  w;
                        r = exp_addr_q.pop_front();
                        w.sel  = r.sel;
                        w.idx  = r.idx;
                        w.data = mem_fn(r.addr);
                        exp_wr_q.push_back(w);
                    end
                end
                if (!mem_grant) stalls++;
            end else begin
                chk("idle_address", 32'(mem_address), 32'd0);
            end
            if (buf_we) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got sel %0d idx %0d expected no write", buf_sel, buf_idx);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("buf_write", 32'({buf_sel, buf_idx, buf_data}), 32'(w));
                end
            end
            if (done) done_cnt++;
        end
    end

    // Memory responder: data one cycle after accept, grant per mode.
    initial begin
        logic        acc;
        logic [15:0] a;
        forever begin
            @(negedge CLK);
            acc = mem_req && mem_grant;
            a   = mem_address;
            @(posedge CLK);
            #1;
            mem_rdata = acc ? mem_fn(a) : DW'($urandom);
            if (grant_mode == 0)      mem_grant = 1'b1;
            else if (grant_mode == 1) mem_grant = ~mem_grant;
            else                      mem_grant = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_line(input logic [9:0] y);
        NextY = y;
        line_start = 1'b1;
        @(posedge CLK);
        #1;
        line_start = 1'b0;
        load_model(y);
        stalls = 0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        bit seen;
        bit allbusy;
        n = 0;
        seen = 1'b0;
        allbusy = 1'b1;
        while (!seen && n < 400) begin
            @(negedge CLK);
            n++;
            if (!busy) allbusy = 1'b0;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: no done after %0d cycles", tag, n);
        end else begin
            chk({tag, "_row_hit"}, 32'(row_hit), 32'(exp_hit));
            chk({tag, "_busy_while_running"}, 32'(allbusy), 32'd1);
            chk({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
            chk({tag, "_write_left"}, 32'(exp_wr_q.size()), 32'd0);
            if (exp_h == 0 || exp_last)
                chk({tag, "_latency"}, 32'(n), 32'(NS + exp_h * SW + (exp_h > 0 ? 1 : 0) + 1 + stalls));
            @(negedge CLK);
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
            chk({tag, "_done_after"}, 32'(done), 32'd0);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
        chk({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
        chk({tag, "_buf_idx"}, 32'(buf_idx), 32'd0);
        chk({tag, "_row_hit"}, 32'(row_hit), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic set_y(input int s, input int v);
        sprite_y[8*s +: 8] = 8'(v);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // No hits
        sprite_en = 4'b0000;
        start_line(10'd100);
        wait_done("nohit");

        // Single hit: sprite 2 at y=40, line 43
        set_y(2, 40);
        sprite_en = 4'b0100;
        start_line(10'd43);
        wait_done("single");

        // Boundaries on sprite 0
        set_y(0, 40);
        sprite_en = 4'b0001;
        start_line(10'd49);
        wait_done("bottom_row");
        start_line(10'd50);
        wait_done("below");
        start_line(10'd39);
        wait_done("above");
        set_y(0, 250);
        start_line(10'd259);
        wait_done("y250");

        // All four hit with toggling grant
        for (int s = 0; s < NS; s++) set_y(s, 60 + s);
        sprite_en = 4'b1111;
        grant_mode = 1;
        start_line(10'd65);
        wait_done("stall");
        grant_mode = 0;

        // Abort mid-fetch, restart on a line hit only by sprites 2 and 3
        done_cnt = 0;
        start_line(10'd65);
        repeat (19) @(posedge CLK);
        #1;
        start_line(10'd71);
        wait_done("abort");
        repeat (3) @(negedge CLK);
        chk("abort_done_count", 32'(done_cnt), 32'd1);
        @(posedge CLK);
        #1;

        // Reset during FETCH
        start_line(10'd65);
        repeat (15) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        exp_addr_q.delete();
        exp_wr_q.delete();
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midreset");
        @(posedge CLK);
        #1;
        start_line(10'd66);
        wait_done("after_reset");

        // Randomized lines
        for (int t = 0; t < 30; t++) begin
            int tgt;
            int ny;
            for (int s = 0; s < NS; s++) set_y(s, int'($urandom_range(0, 255)));
            sprite_en  = NS'($urandom);
            grant_mode = int'($urandom_range(0, 2));
            tgt = int'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 4) == 0) ny = int'($urandom_range(0, 1023));
            else ny = int'(sprite_y[8*tgt +: 8]) + int'($urandom_range(0, 11)) - 1;
            start_line(10'(ny));
            wait_done("random");
        end
        grant_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
